// File: rtl/noc_packet_injector_if.sv
// Processor-side message channel and router local-port channel.
// master: injector side. slave: processor/router environment side.
interface noc_packet_injector_if #(
  parameter int n = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_dest_x;
  logic [1:0]   in_dest_y;
  logic [n-5:0] in_payload;
  logic         out_req;
  logic [n-1:0] out_data;
  logic         out_ack;

  modport master (
    input  in_valid,
    input  in_dest_x,
    input  in_dest_y,
    input  in_payload,
    input  out_ack,
    output in_ready,
    output out_req,
    output out_data
  );

  modport slave (
    output in_valid,
    output in_dest_x,
    output in_dest_y,
    output in_payload,
    output out_ack,
    input  in_ready,
    input  out_req,
    input  out_data
  );
endinterface

// File: rtl/noc_packet_injector.sv
// NoC local-port injector: buffers {dest, payload} messages in a FIFO
// and sends them as packets over a 4-phase req/ack router port.
// Ports: clk, rst_n (async low), bus (message in + router out),
//        busy, err_drop (illegal dest pulse), sent_count (wraps).
module noc_packet_injector #(
  parameter int n          = 32,
  parameter int n_x        = 2,
  parameter int n_y        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_packet_injector_if.master bus,
  output logic             busy,
  output logic             err_drop,
  output logic [CNT_W-1:0] sent_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [2:0]  NX_C    = 3'(n_x);
  localparam logic [2:0]  NY_C    = 3'(n_y);
  localparam logic [GW-1:0] GAP_LD =
    GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GONE_C = GW'(1);
  localparam logic [CNT_W-1:0] CONE_C = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] REL  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] gap_cnt;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [n-1:0]  mem [FIFO_DEPTH];

  logic accept;
  logic legal;
  logic push;
  logic pop;

  assign bus.in_ready = (count != DEPTH_C);
  assign accept = bus.in_valid && bus.in_ready;
  assign legal  = ({1'b0, bus.in_dest_x} < NX_C)
               && ({1'b0, bus.in_dest_y} < NY_C);
  assign push   = accept && legal;
  assign pop    = (state == IDLE) && (count != '0);
  assign busy   = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.in_dest_x, bus.in_dest_y,
                      bus.in_payload};
  end

  // Pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= accept && !legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // RELEASE waits for ack low so a new request never
  // overlaps the previous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      sent_count   <= '0;
      bus.out_req  <= 1'b0;
      bus.out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            bus.out_data <= mem[rd_ptr];
            bus.out_req  <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.out_ack) begin
            bus.out_req <= 1'b0;
            sent_count  <= sent_count + CONE_C;
            state       <= REL;
          end
        end
        REL: begin
          if (!bus.out_ack) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LD;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GONE_C;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
